// File: rtl/mul_ctrl_pkg.sv
// Shared types and defaults for the serial-multiplier sharing controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mul_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_WIDTH   = 4;
    localparam int DEF_MUL_LAT = 8;

    // Width of a counter that must hold 0..lat-1 (never narrower than 1 bit).
    function automatic int cnt_width(input int lat);
        return (lat <= 1) ? 1 : $clog2(lat);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first valid requester at or after rr_ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is used.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             grant_vld
);

    // Scan from the farthest candidate down to rr_ptr so the closest valid one wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant_id  = '0;
        grant_vld = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (req_valid[idx]) begin
                grant_id  = ID_W'(idx);
                grant_vld = 1'b1;
            end
        end
        grant           = '0;
        grant[grant_id] = grant_vld;
    end

endmodule

// File: rtl/mul_share_ctrl.sv
// Shares one serial multiplier among N_REQ requesters, round-robin, one op at a time.
// Latency: accept at T, mul_start T+1..T+MUL_LAT, response valid from T+MUL_LAT+1.
// Backpressure: response held until rsp_ready; no new request accepted until then.
module mul_share_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [2*WIDTH-1:0]     rsp_result,
    output logic                   mul_start,
    output logic [WIDTH-1:0]       mul_operA,
    output logic [WIDTH-1:0]       mul_operB,
    input  logic [2*WIDTH-1:0]     mul_result,
    output logic                   busy
);

    localparam int               CNT_W    = cnt_width(MUL_LAT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

    state_t           state;
    state_t           state_nxt;
    logic [ID_W-1:0]  rr_ptr;
    logic [CNT_W-1:0] cnt;
    logic [ID_W-1:0]  gid;

    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic             grant_vld;
    logic             run_done;
    logic             rsp_ack;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_vld (grant_vld)
    );

    assign run_done  = (state == RUN) && (cnt == CNT_LAST);
    assign rsp_ack   = (state == RESP) && rsp_valid && rsp_ready;
    // Grants only exist in IDLE and never while reset is applied.
    assign req_ready = ((state == IDLE) && rst) ? grant : '0;
    assign mul_start = (state == RUN);
    assign busy      = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: IDLE -> RUN on a grant, RUN -> RESP after MUL_LAT cycles, RESP -> IDLE on ack.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld) state_nxt = RUN;
            RUN:     if (run_done)  state_nxt = RESP;
            RESP:    if (rsp_ack)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, latency counter, response register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr     <= '0;
            cnt        <= '0;
            gid        <= '0;
            mul_operA  <= '0;
            mul_operB  <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        mul_operA <= req_a[int'(grant_id)*WIDTH +: WIDTH];
                        mul_operB <= req_b[int'(grant_id)*WIDTH +: WIDTH];
                        gid       <= grant_id;
                        cnt       <= '0;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (run_done) begin
                        rsp_result <= mul_result;
                        rsp_valid  <= 1'b1;
                        rsp_id     <= gid;
                    end
                end
                RESP: begin
                    if (rsp_ack) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= (gid == ID_LAST) ? '0 : gid + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
